fetch_inst_queue: RTL

FETCH_INST_QUEUE -- requirements
Module: fetch_inst_queue

---
 rtl/fetch_inst_queue.sv | 63 ++++++
 1 files changed

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: buffers inst SRAM responses between Fetch and Decode.
// A pending slot holds each request's tag until the SRAM answers on the next cycle.
module fetch_inst_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  input  logic        req_ex,
  input  logic [7:0]  req_ecode,
  input  logic        req_esubcode,
  input  logic [31:0] inst_sram_rdata,
  input  logic        flush,
  output logic        q_allowin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [73:0] out_bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [73:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pend_q, pend_d;
  logic [41:0]   pbus_q, pbus_d;
  logic          accept, push, pop;
  // pending counts as occupied so its response always has a free slot
  assign q_allowin = (count_q + CW'(pend_q)) < CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign out_bus   = mem_q[rptr_q];
  assign accept    = req_valid && q_allowin && !flush;
  assign push      = pend_q && !flush;
  assign pop       = out_valid && out_ready && !flush;
  always_comb begin
    pend_d  = accept;
    pbus_d  = accept ? {req_pc, req_ex, req_ecode, req_esubcode} : pbus_q;
    wptr_d  = flush ? '0 : wptr_q + AW'(push);
    rptr_d  = flush ? '0 : rptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      pbus_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      pbus_q  <= pbus_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
  // faulting fetches carry NOP_INST so Decode sees a harmless word
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem_q[wptr_q] <= {pbus_q[41:10], pbus_q[9] ? NOP_INST : inst_sram_rdata, pbus_q[9:0]};
  end
endmodule
